thcattus_uart_rx: RTL and testbench
===================================

THCATTUS_UART_RX -- requirements
Module: thcattus_uart_rx

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 4, setting the output word width in bytes; legal range is 1..16.
REQ-002 The module SHALL have parameter CLOCK_FREQ, default 50_000_000, giving the clock frequency in Hz.
REQ-003 The module SHALL have parameter BAUD_RATE, default 115200, giving the line bit rate; CYCLE_PER_BAUD = CLOCK_FREQ/BAUD_RATE (integer division), required >= 4.
REQ-004 The module SHALL have port axis_aclk, input, 1 bit: the single clock; every flop uses its rising edge.
REQ-005 The module SHALL have port axis_arestn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The module SHALL have port uart_rx, input, 1 bit: the asynchronous serial line, idle high.
REQ-007 The module SHALL have port axis_tvalid, output, 1 bit: the AXI-Stream master valid.
REQ-008 The module SHALL have port axis_tready, input, 1 bit: the AXI-Stream master ready.
REQ-009 The module SHALL have port axis_tdata, output, DATA_WIDTH*8 bits: the assembled word.
REQ-010 The module SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a stop-bit error.
REQ-011 The module SHALL have port overrun, output, 1 bit: a one-cycle pulse when a completed word is dropped.

Function
REQ-012 uart_rx SHALL pass through a 2-flop synchronizer (rx_s); all decisions SHALL use rx_s only.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, STOP and BREAK.
REQ-014 In IDLE, rx_s==0 SHALL move to START and clear the 32-bit baud counter.
REQ-015 START SHALL count to CYCLE_PER_BAUD/2-1, then sample rx_s: 0 moves to DATA with the counter cleared; 1 is treated as a glitch and returns to IDLE with no output.
REQ-016 DATA SHALL sample rx_s each time the counter reaches CYCLE_PER_BAUD-1 and then clear the counter; the frame SHALL be 8 bits, LSB first, shifted into an 8-bit shift register; after bit 7 the FSM moves to STOP.
REQ-017 In STOP, at count CYCLE_PER_BAUD-1, rx_s==1 SHALL be treated as a valid byte, store it into byte lane byte_cnt and return to IDLE.
REQ-018 In STOP, at count CYCLE_PER_BAUD-1, rx_s==0 SHALL pulse frame_err for 1 cycle, discard the byte, reset byte_cnt to 0 (dropping the partial word) and enter BREAK.
REQ-019 BREAK SHALL wait for rx_s==1, then enter IDLE.
REQ-020 The first received byte SHALL occupy axis_tdata[7:0] and byte k SHALL occupy [k*8+:8], matching the thcattus_uart_tx byte order.
REQ-021 byte_cnt (8 bits) SHALL increment per valid byte; on reaching DATA_WIDTH-1 plus a valid byte, the full word SHALL be complete and byte_cnt SHALL wrap to 0.
REQ-022 A completed word SHALL be copied into the output register with axis_tvalid=1 on the clock edge following the final stop-bit sample (latency 1 cycle).
REQ-023 The output register SHALL remain stable while axis_tvalid=1 and axis_tready=0 (AXIS hold rule); axis_tvalid SHALL NOT depend combinationally on axis_tready.
REQ-024 axis_tvalid SHALL clear on the edge where axis_tvalid&&axis_tready, unless a new word completes in that same cycle, in which case the new word SHALL load and axis_tvalid SHALL stay 1.
REQ-025 A word completing while axis_tvalid=1 and axis_tready=0 SHALL be dropped with overrun pulsed for 1 cycle; the held word SHALL be unchanged and reception SHALL continue.
REQ-026 Reception SHALL never stall on axis_tready.

Reset
REQ-027 While axis_arestn=0, the module SHALL hold: state IDLE; axis_tvalid=0, axis_tdata=0, frame_err=0, overrun=0; byte_cnt=0, baud counter=0, shift register=0; synchronizer flops=1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame and partial word; after release, reception SHALL restart only on a new falling edge.

Verification (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, CYCLE_PER_BAUD=10, DATA_WIDTH=4)
REQ-029 Sending bytes 0x78,0x56,0x34,0x12 with tready=1 SHALL give one beat of axis_tdata=0x12345678, with tvalid high 1 cycle after the 4th stop sample.
REQ-030 A 3-cycle low glitch on uart_rx SHALL produce no byte, no frame_err and byte_cnt unchanged.
REQ-031 Sending 0xAA with stop bit=0 as the 2nd byte, then line high, then 0x04,0x03,0x02,0x01 SHALL give a frame_err pulse and then axis_tdata=0x01020304.
REQ-032 Holding tready=0 and sending 8 bytes 0x01..0x08 SHALL give tdata=0x04030201 held with tvalid=1, and one overrun pulse; after tready=1, exactly one beat.
REQ-033 Asserting reset during bit 3 of the 2nd byte, then sending 0x11,0x22,0x33,0x44 SHALL give axis_tdata=0x44332211.
REQ-034 Sending 8 back-to-back bytes with tready=1 SHALL give two consecutive beats, 0x04030201 then 0x08070605, with no overrun.

Source files
------------

// File: rtl/thcattus_uart_rx.sv
// UART receiver that packs DATA_WIDTH bytes (first byte in the low lane) into one AXI-Stream beat.
// Frame: 1 start bit, 8 data bits LSB first, 1 stop bit; reception never waits on axis_tready.
`timescale 1ns/1ps
module thcattus_uart_rx #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200
) (
    input  logic                    axis_aclk,
    input  logic                    axis_arestn,
    input  logic                    uart_rx,
    output logic                    axis_tvalid,
    input  logic                    axis_tready,
    output logic [DATA_WIDTH*8-1:0] axis_tdata,
    output logic                    frame_err,
    output logic                    overrun
);

    localparam int unsigned CyclePerBaud = CLOCK_FREQ / BAUD_RATE;
    localparam logic [31:0] BaudLast     = 32'(CyclePerBaud - 1);
    localparam logic [31:0] HalfLast     = 32'(CyclePerBaud / 2 - 1);
    localparam logic [7:0]  LastByte     = 8'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e                  r_state, w_state_nxt;
    logic                    r_rx_meta, r_rx_s;
    logic [31:0]             r_baud_cnt, w_baud_nxt;
    logic [2:0]              r_bit_idx, w_bit_nxt;
    logic [7:0]              r_shift, w_shift_nxt;
    logic [7:0]              r_byte_cnt, w_byte_cnt_nxt;
    logic [DATA_WIDTH*8-1:0] r_word, w_word_nxt;
    logic [DATA_WIDTH*8-1:0] r_tdata;
    logic                    r_tvalid, r_frame_err, r_overrun;
    logic                    w_byte_ok, w_frame_err, w_word_done;

    always_ff @(posedge axis_aclk or negedge axis_arestn) begin
        if (!axis_arestn) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_baud_nxt     = r_baud_cnt;
        w_bit_nxt      = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_byte_cnt_nxt = r_byte_cnt;
        w_byte_ok      = 1'b0;
        w_frame_err    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!r_rx_s) begin
                    w_state_nxt = StStart;
                    w_baud_nxt  = '0;
                end
            end
            StStart: begin
                if (r_baud_cnt == HalfLast) begin
                    // A start bit that has vanished by mid-bit is a glitch.
                    w_state_nxt = r_rx_s ? StIdle : StData;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                end else begin
                    w_baud_nxt = r_baud_cnt + 32'd1;
                end
            end
            StData: begin
                if (r_baud_cnt == BaudLast) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_bit_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = StStop;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 32'd1;
                end
            end
            StStop: begin
                if (r_baud_cnt == BaudLast) begin
                    w_baud_nxt = '0;
                    if (r_rx_s) begin
                        w_byte_ok      = 1'b1;
                        w_state_nxt    = StIdle;
                        w_byte_cnt_nxt = (r_byte_cnt == LastByte) ? 8'd0 : r_byte_cnt + 8'd1;
                    end else begin
                        w_frame_err    = 1'b1;
                        w_byte_cnt_nxt = 8'd0;
                        w_state_nxt    = StBreak;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 32'd1;
                end
            end
            StBreak: begin
                if (r_rx_s) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_word_nxt = r_word;
        if (w_byte_ok) begin
            for (int i = 0; i < int'(DATA_WIDTH); i++) begin
                if (r_byte_cnt == 8'(i)) begin
                    w_word_nxt[i*8 +: 8] = r_shift;
                end
            end
        end
    end

    assign w_word_done = w_byte_ok && (r_byte_cnt == LastByte);

    always_ff @(posedge axis_aclk or negedge axis_arestn) begin
        if (!axis_arestn) begin
            r_state    <= StIdle;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_word     <= w_word_nxt;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_arestn) begin
        if (!axis_arestn) begin
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= 1'b0;
            if (w_word_done) begin
                // The output slot is free if empty or being drained this cycle.
                if (!r_tvalid || axis_tready) begin
                    r_tdata  <= w_word_nxt;
                    r_tvalid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_tvalid && axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign axis_tvalid = r_tvalid;
    assign axis_tdata  = r_tdata;
    assign frame_err   = r_frame_err;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_thcattus_uart_rx.sv
// Directed bench for thcattus_uart_rx: expected words are queued as bytes are sent and
// compared when beats are accepted; hold rule, pulses and latency are checked too.
`timescale 1ns/1ps
module tb_thcattus_uart_rx;

    localparam int unsigned Dw  = 4;
    localparam int unsigned Cf  = 1_000_000;
    localparam int unsigned Br  = 100_000;
    localparam int unsigned Cpb = Cf / Br;

    logic        clk    = 1'b0;
    logic        rstn   = 1'b0;
    logic        rx     = 1'b1;
    logic        tready = 1'b0;
    logic        tvalid;
    logic [31:0] tdata;
    logic        ferr;
    logic        ovr;

    thcattus_uart_rx #(
        .DATA_WIDTH (Dw),
        .CLOCK_FREQ (Cf),
        .BAUD_RATE  (Br)
    ) dut (
        .axis_aclk   (clk),
        .axis_arestn (rstn),
        .uart_rx     (rx),
        .axis_tvalid (tvalid),
        .axis_tready (tready),
        .axis_tdata  (tdata),
        .frame_err   (ferr),
        .overrun     (ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    int          n_beats  = 0;
    int          n_ferr   = 0;
    int          n_ovr    = 0;
    int          rise_cyc = -1;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_data  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: sample half a cycle away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_valid = 1'b0;
            end else begin
                if (prev_valid && !prev_ready) begin
                    check("hold_valid", {31'd0, tvalid}, 32'd1);
                    check("hold_data", tdata, prev_data);
                end
                if (tvalid && !prev_valid) rise_cyc = cyc;
                if (ferr) n_ferr++;
                if (ovr) n_ovr++;
                if (tvalid && tready) begin
                    n_beats++;
                    if (exp_q.size() > 0) begin
                        check("beat_data", tdata, exp_q.pop_front());
                    end else begin
                        n_assert++;
                        n_fail++;
                        $error("FAIL unexpected_beat: observed 0x%0h expected no beat", tdata);
                    end
                end
                prev_valid = tvalid;
                prev_ready = tready;
                prev_data  = tdata;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rx = 1'b0;
        tick(Cpb);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(Cpb);
        end
        rx = stop_bit;
        tick(Cpb);
        rx = 1'b1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            tick(1);
            k++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    int c0;
    int beats0;
    int ferr0;
    int ovr0;
    logic [7:0] pb;

    initial begin
        // Reset state
        tick(5);
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_ferr", {31'd0, ferr}, 32'd0);
        check("rst_ovr", {31'd0, ovr}, 32'd0);
        rstn = 1'b1;
        tick(5);
        tready = 1'b1;

        // Basic word and latency
        beats0 = n_beats;
        exp_q.push_back(32'h1234_5678);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        c0 = cyc;
        send_byte(8'h12);
        tick(2);
        check("latency", 32'(rise_cyc), 32'(c0 + 98));
        drain("basic_drain");
        check("basic_beats", 32'(n_beats - beats0), 32'd1);

        // Glitch between bytes of one word
        beats0 = n_beats;
        ferr0  = n_ferr;
        exp_q.push_back(32'h0d0c_0b0a);
        send_byte(8'h0a);
        send_byte(8'h0b);
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        send_byte(8'h0c);
        send_byte(8'h0d);
        drain("glitch_drain");
        check("glitch_ferr", 32'(n_ferr - ferr0), 32'd0);
        check("glitch_beats", 32'(n_beats - beats0), 32'd1);

        // Frame error drops the partial word
        beats0 = n_beats;
        ferr0  = n_ferr;
        exp_q.push_back(32'h0102_0304);
        send_byte(8'h99);
        send_byte(8'haa, 1'b0);
        tick(20);
        check("ferr_pulse", 32'(n_ferr - ferr0), 32'd1);
        send_byte(8'h04);
        send_byte(8'h03);
        send_byte(8'h02);
        send_byte(8'h01);
        drain("ferr_drain");
        check("ferr_beats", 32'(n_beats - beats0), 32'd1);

        // Overrun with tready held low
        tready = 1'b0;
        beats0 = n_beats;
        ovr0   = n_ovr;
        exp_q.push_back(32'h0403_0201);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        tick(5);
        check("ovr_tvalid", {31'd0, tvalid}, 32'd1);
        check("ovr_tdata", tdata, 32'h0403_0201);
        check("ovr_pulse", 32'(n_ovr - ovr0), 32'd1);
        check("ovr_no_beat", 32'(n_beats - beats0), 32'd0);
        tready = 1'b1;
        tick(30);
        check("ovr_one_beat", 32'(n_beats - beats0), 32'd1);
        check("ovr_queue", 32'(exp_q.size()), 32'd0);
        check("ovr_tvalid_clr", {31'd0, tvalid}, 32'd0);

        // Reset mid-frame during bit 3 of the second byte
        send_byte(8'h55);
        pb = 8'hc3;
        rx = 1'b0;
        tick(Cpb);
        for (int i = 0; i < 3; i++) begin
            rx = pb[i];
            tick(Cpb);
        end
        rx = pb[3];
        tick(4);
        rstn = 1'b0;
        rx   = 1'b1;
        tick(3);
        check("midrst_tvalid", {31'd0, tvalid}, 32'd0);
        check("midrst_tdata", tdata, 32'd0);
        rstn = 1'b1;
        tick(5);
        beats0 = n_beats;
        exp_q.push_back(32'h4433_2211);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        drain("midrst_drain");
        check("midrst_beats", 32'(n_beats - beats0), 32'd1);

        // Back-to-back words
        beats0 = n_beats;
        ovr0   = n_ovr;
        exp_q.push_back(32'h0403_0201);
        exp_q.push_back(32'h0807_0605);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        drain("b2b_drain");
        tick(10);
        check("b2b_beats", 32'(n_beats - beats0), 32'd2);
        check("b2b_ovr", 32'(n_ovr - ovr0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
